// File: rtl/fifo_arb_pkg.sv
// Shared types, widths and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter lock state: IDLE holds no lock, BURST holds an owner.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Width of the back-pressure cycle counter.
    localparam int STALL_W = 16;

    // Round-robin successor of idx among n producers.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-start priority encoder: finds the first asserted request at or
// after 'start', wrapping around from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester after 'start' is the last one written and therefore wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                idx = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port scheduler for the async FIFO: round-robin between NREQ
// producers with a burst lock of up to MAX_BURST words, gated on 'full'.
//
// Handshake: a producer raises req[i] with its word on req_data and holds
// both stable; the word is taken in the cycle where gnt[i] is high (that
// cycle wr_rq is high and wdata carries the word). There is no separate
// ready: gnt is the ready, qualified by req, and is low while full is high.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     w_clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     full,
    output logic                     wr_rq,
    output logic [WIDTH-1:0]         wdata,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [STALL_W-1:0]       stall_cnt
);

    localparam int IW = $clog2(NREQ);
    // burst_cnt only ever holds 1..MAX_BURST-1.
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q;

    logic            lock_hit;
    logic [IW-1:0]   pick_start;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            cand_valid;
    logic            accept;
    logic [IW-1:0]   owner_succ;

    assign owner_succ = IW'(rr_next(int'(owner_q), NREQ));

    // The owner keeps the port while it still requests; otherwise search
    // starts after the owner (lock released) or at rr_ptr (no lock).
    assign lock_hit   = (state_q == ARB_BURST) && req[owner_q];
    assign pick_start = (state_q == ARB_IDLE) ? rr_ptr_q : owner_succ;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign cand       = lock_hit ? owner_q : pick_idx;
    assign cand_valid = lock_hit | pick_valid;

    // Reset masks the grant so a word in flight during reset is dropped.
    assign accept = cand_valid && !full && rst_n;

    // Combinational grant path and data mux.
    always_comb begin
        gnt   = '0;
        wr_rq = accept;
        wdata = req_data[int'(cand)*WIDTH +: WIDTH];
        if (accept) begin
            gnt = NREQ'(1) << cand;
        end
    end

    assign busy      = (state_q == ARB_BURST);
    assign owner     = busy ? owner_q : '0;
    assign stall_cnt = stall_q;

    // Next-state logic for the burst lock and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = IW'(rr_next(int'(cand), NREQ));
                    end else begin
                        state_d = ARB_BURST;
                        owner_d = cand;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ARB_BURST: begin
                if (lock_hit) begin
                    // full=1 leaves the lock untouched.
                    if (!full) begin
                        if (cnt_q == CW'(MAX_BURST - 1)) begin
                            state_d  = ARB_IDLE;
                            rr_ptr_d = owner_succ;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else if (accept) begin
                    // Owner dropped req: a new producer takes over without a
                    // bubble, exactly as a fresh accept from IDLE.
                    if (MAX_BURST == 1) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = IW'(rr_next(int'(cand), NREQ));
                    end else begin
                        owner_d = cand;
                        cnt_d   = CW'(1);
                    end
                end else begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = owner_succ;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    // Saturating count of cycles where a producer waits on a full FIFO.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (full && (|req) && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side scheduler that shares the single write port of the asynchronous FIFO between `NREQ` producers in the write clock domain. It arbitrates round-robin with a bounded burst lock: a granted producer keeps the port for up to `MAX_BURST` consecutive words. It gates every write on the FIFO's `full` flag and counts cycles lost to back-pressure. It sits between the producers and the FIFO's `wr_rq`/`wdata`/`full` pins.

## Interface
- `WIDTH`, 8: data word width; must match the FIFO.
- `NREQ`, 4: number of producers, at least 2.
- `MAX_BURST`, 4: maximum consecutive words per grant, at least 1.

Ports:
- `w_clk`  in  1: write-domain clock; all state is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: per-producer write request; the word is valid while high.
- `req_data`  in  NREQ*WIDTH: producer i's word occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  NREQ: one-hot; the word from producer i is accepted this cycle.
- `full`  in  1: FIFO full flag, same clock domain.
- `wr_rq`  out  1: FIFO write strobe.
- `wdata`  out  WIDTH: FIFO write data.
- `owner`  out  $clog2(NREQ): current burst owner; 0 when idle.
- `busy`  out  1: a burst is in progress (state is BURST).
- `stall_cnt`  out  16: saturating count of back-pressure cycles.

## Operation
- State machine has two states.
  - IDLE: no lock held. Holds `rr_ptr`.
  - BURST: holds `owner` and `burst_cnt`, where 1 ≤ `burst_cnt` < MAX_BURST.
- Candidate selection each cycle:
  - In BURST with `req[owner]` high, the candidate is `owner`.
  - Otherwise the candidate is the first requester with `req` high, searching upward with wrap from a start index.
  - The start index is `rr_ptr` in IDLE, and `owner+1` mod NREQ in BURST.
- Accept rule: the candidate is accepted only when `full`=0.
  - On accept: `gnt[cand]`=1, `wr_rq`=1, `wdata`=`req_data[cand]`.
  - If no candidate exists or `full`=1: `gnt`=0, `wr_rq`=0. `wdata` is don't-care but is driven by the candidate's data.
- State transitions:
  - IDLE, accept, MAX_BURST=1: stay in IDLE; `rr_ptr` ← cand+1 mod NREQ.
  - IDLE, accept, MAX_BURST>1: go to BURST; `owner` ← cand; `burst_cnt` ← 1.
  - BURST, owner accepted, `burst_cnt`+1 = MAX_BURST: go to IDLE; `rr_ptr` ← owner+1.
  - BURST, owner accepted otherwise: `burst_cnt` increments.
  - BURST, `req[owner]`=0: the lock is released in the same cycle. A different candidate may be accepted that cycle, with no bubble, and is handled exactly as an IDLE accept. With no accept, go to IDLE with `rr_ptr` ← owner+1.
  - BURST, `full`=1 with `req[owner]` high: hold state; `owner` and `burst_cnt` are unchanged.
- `stall_cnt` increments in any cycle where `full`=1 and `req` is nonzero. It saturates at 16'hFFFF and clears only on reset.
- A producer must hold `req` and its data stable until it sees `gnt`. The arbiter never drops or duplicates an accepted word.

## Timing
- Grant path is combinational, with zero-cycle latency: `gnt`, `wr_rq` and `wdata` depend on `req`, `full` and the registered state.
- State updates on the `w_clk` edge that follows the accept.
- While `rst_n`=0:
  - `gnt` and `wr_rq` are forced to 0, regardless of `req`.
  - State = IDLE, `rr_ptr`=0, `owner`=0, `busy`=0, `stall_cnt`=0.
- Reset asserted mid-burst aborts the burst immediately. The word in flight that cycle is not written.
- `full` is registered in `w_clk` by the FIFO's full logic. Gating combinationally on `full` therefore never writes into a full FIFO.
- Fairness: every requester holding `req` is granted within (NREQ-1)·MAX_BURST accepted words.

## Structure
- Package `fifo_arb_pkg` contains:
  - `arb_state_t` enum {ARB_IDLE, ARB_BURST};
  - `STALL_W`=16;
  - the function `rr_next(idx, n)`, which returns (idx+1) mod n.
- Sub-module `rr_pick`: rotating-start priority encoder. Inputs are `req` and `start`; outputs are `valid` and `idx`. The arbiter instantiates it once.
- The data mux is in the top level, indexed by the candidate.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=4'b1111 and `full`=0 → `gnt`=0, `wr_rq`=0, `stall_cnt`=0, `busy`=0. Release reset → first grant goes to producer 0 on the next cycle.
- **Single producer:** `req`=4'b0001 held, data 0x10, 0x11, … → `wr_rq`=1 every cycle and data in order. `busy` drops for one cycle after each 4 words, with no write bubble.
- **All producers:** `req`=4'b1111 held → `gnt` sequence is 0×4, 1×4, 2×4, 3×4, 0…, with `owner` matching.
- **Back-pressure mid-burst:** producer 1 writes 2 words, then `full`=1 for 3 cycles → `gnt`=0, `owner`=1, `stall_cnt`=3. After `full` drops, producer 1 writes 2 more words, then producer 2 is granted.
- **Early release:** producer 0 drops `req` after 1 word while `req[2]`=1 → `gnt`=4'b0100 in that same cycle, and the next burst is owned by producer 2.
- **Saturation:** `full`=1 with `req`≠0 for 70000 cycles → `stall_cnt` holds at 16'hFFFF.
